ripple_count_monitor: RTL

// Sits directly downstream of the 4-bit JK ripple down counter and consumes its raw L[3:0] outputs.

---
 rtl/ripple_count_monitor_if.sv | 25 ++
 rtl/ripple_count_monitor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ripple_count_monitor_if.sv
// Bus between the ripple down counter's raw outputs, the monitor, and its display/status consumers.
`timescale 1ns/1ps
interface ripple_count_monitor_if #(
    parameter int WRAP_W = 8
);
    logic [3:0]        cnt_in;
    logic              err_clr;
    logic [3:0]        cnt_q;
    logic              cnt_upd;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err_skip;
    logic [6:0]        seg;
    logic [1:0]        an;

    modport master (
        output cnt_in, err_clr,
        input  cnt_q, cnt_upd, wrap_pulse, wrap_cnt, err_skip, seg, an
    );

    modport slave (
        input  cnt_in, err_clr,
        output cnt_q, cnt_upd, wrap_pulse, wrap_cnt, err_skip, seg, an
    );
endinterface

// File: rtl/ripple_count_monitor.sv
// Synchronises and debounces a glitchy ripple down counter, checks each accepted step,
// counts 0->15 wraps and scans the count / wrap count onto a 2-digit active-low 7-seg display.
`timescale 1ns/1ps
module ripple_count_monitor #(
    parameter int STABLE_CYC = 4,
    parameter int SCAN_DIV   = 16,
    parameter int WRAP_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ripple_count_monitor_if.slave bus
);

    localparam int STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    logic [3:0]        sync1;
    logic [3:0]        sync2;
    logic [3:0]        cand;
    logic [STAB_W-1:0] stab;
    logic [SCAN_W-1:0] scan;
    logic              sel;

    logic [3:0]        cnt_r;
    logic              upd_r;
    logic              wrap_r;
    logic [WRAP_W-1:0] wrap_cnt_r;
    logic              err_r;
    logic [6:0]        seg_r;
    logic [1:0]        an_r;

    logic accept;
    logic step_ok;
    logic is_wrap;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A candidate is accepted only after it has survived the full stability window unchanged.
    assign accept  = (sync2 == cand) && (stab == STAB_MAX) && (cand != cnt_r);
    assign step_ok = (cand == cnt_r - 4'd1);
    assign is_wrap = accept && (cnt_r == 4'd0) && (cand == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            cand       <= '0;
            stab       <= '0;
            scan       <= '0;
            sel        <= 1'b0;
            cnt_r      <= '0;
            upd_r      <= 1'b0;
            wrap_r     <= 1'b0;
            wrap_cnt_r <= '0;
            err_r      <= 1'b0;
            seg_r      <= 7'h7F;
            an_r       <= 2'b11;
        end else begin
            sync1 <= bus.cnt_in;
            sync2 <= sync1;

            upd_r  <= 1'b0;
            wrap_r <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                stab <= '0;
            end else if (stab != STAB_MAX) begin
                stab <= stab + 1'b1;
            end else if (accept) begin
                cnt_r <= cand;
                upd_r <= 1'b1;
            end

            if (is_wrap) begin
                wrap_r     <= 1'b1;
                wrap_cnt_r <= wrap_cnt_r + 1'b1;
            end

            // A skip detected in this cycle outranks a simultaneous clear request.
            if (accept && !step_ok) begin
                err_r <= 1'b1;
            end else if (bus.err_clr) begin
                err_r <= 1'b0;
            end

            if (scan == SCAN_MAX) begin
                scan <= '0;
                sel  <= ~sel;
            end else begin
                scan <= scan + 1'b1;
            end

            an_r  <= sel ? 2'b01 : 2'b10;
            seg_r <= hex7(sel ? wrap_cnt_r[3:0] : cnt_r);
        end
    end

    assign bus.cnt_q      = cnt_r;
    assign bus.cnt_upd    = upd_r;
    assign bus.wrap_pulse = wrap_r;
    assign bus.wrap_cnt   = wrap_cnt_r;
    assign bus.err_skip   = err_r;
    assign bus.seg        = seg_r;
    assign bus.an         = an_r;

endmodule
